// File: rtl/issue_queue_integer_if.sv
// issue_queue_integer_if: dispatch, CDB and issue signals between front end, queue and execution unit
interface issue_queue_integer_if #(
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  dispatch_en_integer;
  logic [4:0]            dispatch_opcode;
  logic [TAG_WIDTH-1:0]  dispatch_rd_tag;
  logic [DATA_WIDTH-1:0] dispatch_rs1_data;
  logic [TAG_WIDTH-1:0]  dispatch_rs1_tag;
  logic                  dispatch_rs1_valid;
  logic [DATA_WIDTH-1:0] dispatch_rs2_data;
  logic [TAG_WIDTH-1:0]  dispatch_rs2_tag;
  logic                  dispatch_rs2_valid;
  logic [DATA_WIDTH-1:0] dispatch_imm;
  logic                  CDB_valid;
  logic [TAG_WIDTH-1:0]  CDB_tag;
  logic [DATA_WIDTH-1:0] CDB_data;
  logic                  issue_ready;
  logic                  issueque_full_integer;
  logic                  issue_valid;
  logic [4:0]            issue_opcode;
  logic [TAG_WIDTH-1:0]  issue_rd_tag;
  logic [DATA_WIDTH-1:0] issue_rs1_data;
  logic [DATA_WIDTH-1:0] issue_rs2_data;
  logic [DATA_WIDTH-1:0] issue_imm;
  modport master (
    output dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
           dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_valid,
           dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_valid,
           dispatch_imm, CDB_valid, CDB_tag, CDB_data, issue_ready,
    input  issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
           issue_rs1_data, issue_rs2_data, issue_imm
  );
  modport slave (
    input  dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
           dispatch_rs1_data, dispatch_rs1_tag, dispatch_rs1_valid,
           dispatch_rs2_data, dispatch_rs2_tag, dispatch_rs2_valid,
           dispatch_imm, CDB_valid, CDB_tag, CDB_data, issue_ready,
    output issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
           issue_rs1_data, issue_rs2_data, issue_imm
  );
endinterface

// File: rtl/issue_queue_integer.sv
// issue_queue_integer: collapsing age-ordered issue queue with CDB wakeup for the integer unit
module issue_queue_integer #(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  issue_queue_integer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  typedef struct packed {
    logic [4:0]            op;
    logic [TAG_WIDTH-1:0]  rd;
    logic [TAG_WIDTH-1:0]  t1;
    logic [TAG_WIDTH-1:0]  t2;
    logic [DATA_WIDTH-1:0] d1;
    logic [DATA_WIDTH-1:0] d2;
    logic [DATA_WIDTH-1:0] imm;
    logic                  v1;
    logic                  v2;
  } ent_t;
  ent_t q [DEPTH];
  ent_t woke [DEPTH];
  ent_t nq [DEPTH];
  ent_t din;
  logic [CW-1:0] count, widx;
  logic [IW-1:0] sel;
  logic found, iss, acc, full, hit1, hit2;
  assign full = count == CW'(DEPTH);
  assign bus.issueque_full_integer = full;
  assign acc = bus.dispatch_en_integer & ~full;
  assign iss = bus.issue_ready & found;
  assign widx = count - CW'(iss);
  assign hit1 = bus.CDB_valid && bus.CDB_tag == bus.dispatch_rs1_tag && !bus.dispatch_rs1_valid;
  assign hit2 = bus.CDB_valid && bus.CDB_tag == bus.dispatch_rs2_tag && !bus.dispatch_rs2_valid;
  // Oldest occupied entry whose operands were both ready at the last edge
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (CW'(i) < count && q[i].v1 && q[i].v2) begin
        found = 1'b1;
        sel = IW'(i);
      end
  end
  // Incoming entry, capturing a CDB broadcast that matches a missing source in the same cycle
  always_comb begin
    din.op  = bus.dispatch_opcode;
    din.rd  = bus.dispatch_rd_tag;
    din.t1  = bus.dispatch_rs1_tag;
    din.t2  = bus.dispatch_rs2_tag;
    din.d1  = hit1 ? bus.CDB_data : bus.dispatch_rs1_data;
    din.d2  = hit2 ? bus.CDB_data : bus.dispatch_rs2_data;
    din.imm = bus.dispatch_imm;
    din.v1  = bus.dispatch_rs1_valid | hit1;
    din.v2  = bus.dispatch_rs2_valid | hit2;
  end
  // Wakeup, then collapse over the issued slot, then append the dispatch at the first free slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = q[i];
      if (!q[i].v1 && bus.CDB_valid && bus.CDB_tag == q[i].t1) begin
        woke[i].v1 = 1'b1;
        woke[i].d1 = bus.CDB_data;
      end
      if (!q[i].v2 && bus.CDB_valid && bus.CDB_tag == q[i].t2) begin
        woke[i].v2 = 1'b1;
        woke[i].d2 = bus.CDB_data;
      end
    end
    for (int i = 0; i < DEPTH; i++) nq[i] = woke[i];
    for (int i = 0; i < DEPTH - 1; i++)
      if (iss && IW'(i) >= sel) nq[i] = woke[i + 1];
    if (acc) nq[widx[IW-1:0]] = din;
  end
  // Queue storage and occupancy
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else begin
      count <= count + CW'(acc) - CW'(iss);
      for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
    end
  end
  // Registered issue port; data holds when nothing issues
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.issue_valid    <= 1'b0;
      bus.issue_opcode   <= '0;
      bus.issue_rd_tag   <= '0;
      bus.issue_rs1_data <= '0;
      bus.issue_rs2_data <= '0;
      bus.issue_imm      <= '0;
    end else begin
      bus.issue_valid <= iss;
      if (iss) begin
        bus.issue_opcode   <= q[sel].op;
        bus.issue_rd_tag   <= q[sel].rd;
        bus.issue_rs1_data <= q[sel].d1;
        bus.issue_rs2_data <= q[sel].d2;
        bus.issue_imm      <= q[sel].imm;
      end
    end
  end
endmodule
